// File: rtl/dti_bincnt_seq.sv
// dti_bincnt_seq: job sequencer for the dti_bincnt_ckprn binary counter.
// Queues count-target jobs in a small FIFO, then for each job loads the
// counter, enables it until it reports done (or a watchdog expires) and
// retires the job with a job_done or job_err pulse.
//
// Job handshake: a job transfers on every rising edge where job_valid and
// job_ready are both high. job_ready depends only on FIFO occupancy (never
// on job_valid), and job_target must be stable whenever job_valid is high.
module dti_bincnt_seq #(
    parameter int CNT_W   = 3,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     job_valid,
    input  logic [CNT_W-1:0]         job_target,
    output logic                     job_ready,
    output logic [CNT_W-1:0]         cnt_count_to,
    output logic                     cnt_load,
    output logic                     cnt_count_en,
    input  logic                     cnt_done,
    output logic                     job_done,
    output logic                     job_err,
    output logic [7:0]               jobs_done,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy
);

    localparam int AW   = $clog2(DEPTH);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [AW:0]     DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RETIRE
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [CNT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [WD_W-1:0]  wd;
    logic             status_ok;

    assign full       = (count == DEPTH_L);
    assign empty      = (count == '0);
    assign push       = job_valid && !full;
    assign job_ready  = !full;
    assign fifo_level = count;
    assign busy       = (state != S_IDLE);

    // FIFO storage: written on every accepted job; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= job_target;
        end
    end

    // FIFO pointers and occupancy; a pop never coincides with a full FIFO push.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Next-state and counter-control decode; the head is popped whenever
    // the FSM enters LOAD.
    always_comb begin
        state_nx     = state;
        pop          = 1'b0;
        cnt_load     = 1'b0;
        cnt_count_en = 1'b0;
        job_done     = 1'b0;
        job_err      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nx = S_LOAD;
                    pop      = 1'b1;
                end
            end
            S_LOAD: begin
                cnt_load = 1'b1;
                state_nx = S_RUN;
            end
            S_RUN: begin
                cnt_count_en = 1'b1;
                // cnt_done has priority over the watchdog in the same cycle.
                if (cnt_done || (wd == WD_LAST)) begin
                    state_nx = S_RETIRE;
                end
            end
            S_RETIRE: begin
                job_done = status_ok;
                job_err  = !status_ok;
                if (!empty) begin
                    state_nx = S_LOAD;
                    pop      = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register, target latch, watchdog, retire status and job counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt_count_to <= '0;
            wd           <= '0;
            status_ok    <= 1'b0;
            jobs_done    <= '0;
        end else begin
            state <= state_nx;
            if (pop) begin
                cnt_count_to <= mem[rd_ptr];
            end
            if (state == S_LOAD) begin
                wd <= '0;
            end else if (state == S_RUN) begin
                wd <= wd + 1'b1;
            end
            // Only the value captured on the final RUN cycle matters.
            if (state == S_RUN) begin
                status_ok <= cnt_done;
            end
            if ((state == S_RETIRE) && status_ok) begin
                jobs_done <= jobs_done + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dti_bincnt_seq.sv
// Bench for dti_bincnt_seq: job-level reference model with a per-cycle
// compare, a counter responder driving cnt_done, and directed scenarios
// with hand-computed expectations.
module tb_dti_bincnt_seq;

    localparam int CNT_W   = 3;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int VEC_W   = 6 + CNT_W + LVL_W + 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               job_valid;
    logic [CNT_W-1:0]   job_target;
    logic               job_ready;
    logic [CNT_W-1:0]   cnt_count_to;
    logic               cnt_load;
    logic               cnt_count_en;
    logic               cnt_done;
    logic               job_done;
    logic               job_err;
    logic [7:0]         jobs_done;
    logic [LVL_W-1:0]   fifo_level;
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    dti_bincnt_seq #(.CNT_W(CNT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .job_valid    (job_valid),
        .job_target   (job_target),
        .job_ready    (job_ready),
        .cnt_count_to (cnt_count_to),
        .cnt_load     (cnt_load),
        .cnt_count_en (cnt_count_en),
        .cnt_done     (cnt_done),
        .job_done     (job_done),
        .job_err      (job_err),
        .jobs_done    (jobs_done),
        .fifo_level   (fifo_level),
        .busy         (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // ---------------- reference model ----------------
    // A job lives for age 0 (load), ages 1..n (counting), then one retire
    // cycle. It counts for at most TIMEOUT cycles.
    int m_q[$];
    bit m_valid = 1'b0;
    bit m_active, m_retiring, m_ok;
    int m_age, m_target, m_jobs;

    initial begin
        bit push_ok;
        bit start;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_q.delete();
                m_active = 0; m_retiring = 0; m_ok = 0;
                m_age = 0; m_target = 0; m_jobs = 0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                push_ok = job_valid && (m_q.size() < DEPTH);
                start   = 0;
                if (!m_active) begin
                    start = (m_q.size() > 0);
                end else if (m_age == 0) begin
                    m_age = 1;
                end else if (!m_retiring) begin
                    if (cnt_done) begin
                        m_retiring = 1; m_ok = 1;
                    end else if (m_age == TIMEOUT) begin
                        m_retiring = 1; m_ok = 0;
                    end else begin
                        m_age++;
                    end
                end else begin
                    if (m_ok) m_jobs = (m_jobs + 1) % 256;
                    if (m_q.size() > 0) start = 1;
                    else m_active = 0;
                end
                if (start) begin
                    m_target = m_q.pop_front();
                    m_active = 1; m_age = 0; m_retiring = 0;
                end
                if (push_ok) m_q.push_back(int'(job_target));
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [VEC_W-1:0] got_v;
        logic [VEC_W-1:0] exp_v;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                got_v = {job_ready, cnt_load, cnt_count_en, job_done, job_err, busy,
                         cnt_count_to, fifo_level, jobs_done};
                exp_v = {m_q.size() < DEPTH,
                         m_active && (m_age == 0),
                         m_active && (m_age >= 1) && !m_retiring,
                         m_active && m_retiring && m_ok,
                         m_active && m_retiring && !m_ok,
                         m_active,
                         CNT_W'(m_target), LVL_W'(m_q.size()), 8'(m_jobs)};
                n_checks++;
                if (got_v !== exp_v) begin
                    n_errors++;
                    $display("FAIL cycle_outputs @%0d: got %h expected %h", cyc, got_v, exp_v);
                end
            end
        end
    end

    // ---------------- counter responder ----------------
    // Each job's done arrives on RUN cycle (target+1) unless lim_q supplies
    // an override; an override of 0 means the counter never finishes.
    int lim_q[$];
    int run_k, cur_lim;
    initial begin
        cnt_done = 1'b0; run_k = 0; cur_lim = 0;
        forever begin
            @(posedge clk); #1;
            if (cnt_load === 1'b1) begin
                run_k   = 0;
                cur_lim = (lim_q.size() > 0) ? lim_q.pop_front() : int'(cnt_count_to) + 1;
            end
            if (cnt_count_en === 1'b1) begin
                run_k++;
                cnt_done = (cur_lim != 0) && (run_k >= cur_lim);
            end else begin
                cnt_done = 1'b0;
            end
        end
    end

    // ---------------- event monitor ----------------
    int load_cnt, run_len, en_low, busy_cyc, max_jobs;
    int first_load_cyc, last_load_cyc, last_done_cyc, last_err_cyc, last_cdone_cyc;
    bit en_seen, prev_en;
    int done_t[$], done_r[$], err_t[$], err_r[$], gap_q[$];

    task automatic clear_logs();
        load_cnt = 0; run_len = 0; en_low = 0; busy_cyc = 0; max_jobs = 0;
        first_load_cyc = -1; last_load_cyc = -1; last_done_cyc = -1;
        last_err_cyc = -1; last_cdone_cyc = -1;
        en_seen = 0; prev_en = 0;
        done_t.delete(); done_r.delete(); err_t.delete(); err_r.delete(); gap_q.delete();
    endtask

    initial begin
        clear_logs();
        forever begin
            @(negedge clk);
            if (cnt_load === 1'b1) begin
                load_cnt++; run_len = 0; last_load_cyc = cyc;
                if (first_load_cyc < 0) first_load_cyc = cyc;
            end
            if (cnt_count_en === 1'b1) begin
                if (en_seen && !prev_en) gap_q.push_back(en_low);
                run_len++; en_low = 0; en_seen = 1; prev_en = 1;
            end else begin
                en_low++; prev_en = 0;
            end
            if (cnt_done === 1'b1) last_cdone_cyc = cyc;
            if (job_done === 1'b1) begin
                done_t.push_back(int'(cnt_count_to)); done_r.push_back(run_len); last_done_cyc = cyc;
            end
            if (job_err === 1'b1) begin
                err_t.push_back(int'(cnt_count_to)); err_r.push_back(run_len); last_err_cyc = cyc;
            end
            if (busy === 1'b1) busy_cyc++;
            if (int'(jobs_done) > max_jobs) max_jobs = int'(jobs_done);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input int t);
        int guard = 0;
        job_valid  = 1'b1;
        job_target = CNT_W'(t);
        while (!job_ready && guard < 200) begin
            step(); guard++;
        end
        if (guard >= 200) check("push_ready_timeout", guard, 0);
        step();
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || fifo_level != 0) && n < budget) begin
            step(); n++;
        end
        if (n >= budget) check("idle_timeout", n, 0);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    int'(job_ready), 1);
        check({tag, "_load"},     int'(cnt_load), 0);
        check({tag, "_en"},       int'(cnt_count_en), 0);
        check({tag, "_done"},     int'(job_done), 0);
        check({tag, "_err"},      int'(job_err), 0);
        check({tag, "_busy"},     int'(busy), 0);
        check({tag, "_count_to"}, int'(cnt_count_to), 0);
        check({tag, "_level"},    int'(fifo_level), 0);
        check({tag, "_jobs"},     int'(jobs_done), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; job_valid = 1'b0; job_target = '0;
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        // single job, target 3: done on the 4th counting cycle
        clear_logs();
        push(3);
        wait_idle(60);
        check("t1_loads", load_cnt, 1);
        check("t1_target", q_at(done_t, 0), 3);
        check("t1_en_cycles", q_at(done_r, 0), 4);
        check("t1_done_latency", last_done_cyc - last_cdone_cyc, 1);
        check("t1_jobs_done", int'(jobs_done), 1);
        check("t1_busy", int'(busy), 0);

        // back-to-back jobs while the first is held in RUN
        clear_logs();
        lim_q.push_back(10);
        push(3); push(4); push(0); push(7);
        check("t2_level_after4", int'(fifo_level), 3);
        push(1);
        check("t2_level_full", int'(fifo_level), 4);
        check("t2_ready_full", int'(job_ready), 0);
        job_valid = 1'b1; job_target = 3'd6;
        step(); step();
        job_valid = 1'b0;
        check("t2_rejected_level", int'(fifo_level), 4);
        wait_idle(120);
        check("t2_count", done_t.size(), 5);
        check("t2_order0", q_at(done_t, 0), 3);
        check("t2_order1", q_at(done_t, 1), 4);
        check("t2_order2", q_at(done_t, 2), 0);
        check("t2_order3", q_at(done_t, 3), 7);
        check("t2_order4", q_at(done_t, 4), 1);
        check("t2_gaps", gap_q.size(), 4);
        for (int i = 0; i < 4; i++) check("t2_gap_len", q_at(gap_q, i), 2);
        check("t2_jobs_done", int'(jobs_done), 6);

        // watchdog expiry with a second job queued
        clear_logs();
        lim_q.push_back(0);
        push(5); push(2);
        wait_idle(100);
        check("t3_err_count", err_t.size(), 1);
        check("t3_err_target", q_at(err_t, 0), 5);
        check("t3_err_en_cycles", q_at(err_r, 0), 16);
        check("t3_next_load", last_load_cyc - last_err_cyc, 1);
        check("t3_next_done", q_at(done_t, 0), 2);
        check("t3_jobs_done", int'(jobs_done), 7);

        // done coincides with the last watchdog cycle
        clear_logs();
        lim_q.push_back(16);
        push(6);
        wait_idle(60);
        check("t4_done_target", q_at(done_t, 0), 6);
        check("t4_en_cycles", q_at(done_r, 0), 16);
        check("t4_no_err", err_t.size(), 0);
        check("t4_jobs_done", int'(jobs_done), 8);

        // reset in the middle of RUN with two jobs queued
        clear_logs();
        lim_q.push_back(0);
        push(6); push(1); push(2);
        repeat (4) step();
        check("t5_level_pre", int'(fifo_level), 2);
        check("t5_busy_pre", int'(busy), 1);
        reset = 1'b1;
        step();
        check_reset_outputs("t5");
        reset = 1'b0;
        repeat (4) step();
        check("t5_no_done", done_t.size(), 0);
        check("t5_no_err", err_t.size(), 0);
        check("t5_idle", int'(busy), 0);

        // 256 zero-target jobs: wrap and 3-cycle job cost
        clear_logs();
        for (int i = 0; i < 256; i++) push(0);
        wait_idle(100);
        check("t6_count", done_t.size(), 256);
        check("t6_wrap", int'(jobs_done), 0);
        check("t6_max", max_jobs, 255);
        check("t6_busy_cycles", busy_cyc, 768);
        check("t6_span", last_done_cyc - first_load_cyc + 1, 768);
        check("t6_no_err", err_t.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // overall time limit
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
